// File: rtl/rst_ctrl_pkg.sv
// Shared definitions for the reset controller: FSM state encoding, reset-cause
// codes and the cause-priority helper.
package rst_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_BTN = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;
  localparam logic [1:0] CAUSE_WDT = 2'd3;

  // Simultaneous requests resolve watchdog > software > button.
  function automatic logic [1:0] sel_cause(input logic wdt_req, input logic sw_req);
    if (wdt_req)     return CAUSE_WDT;
    else if (sw_req) return CAUSE_SW;
    else             return CAUSE_BTN;
  endfunction

endpackage

// File: rtl/rst_debounce.sv
// Two-flop synchroniser followed by a debounce filter for an active-low button;
// the filtered level changes only after the input holds a new level long enough.
module rst_debounce
  import rst_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async_n,
  output logic o_db
);

  localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  // Any return to the accepted level restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1  <= 1'b1;
      r_s2  <= 1'b1;
      r_db  <= 1'b1;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_async_n;
      r_s2 <= r_s1;
      if (r_s2 != r_db) begin
        if (r_cnt == LAST) begin
          r_db  <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/rst_ctrl.sv
// Board reset controller: merges POR, debounced button, software request and
// optional watchdog (compiled in with RST_CTRL_WDT_EN) into a stretched reset.
module rst_ctrl
  import rst_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STRETCH_CYCLES  = 1024,
  parameter int WDT_CYCLES      = 16777216
) (
  input  logic       sys_clk_pad_i,
  input  logic       rst_n_pad_i,
  input  logic       btn_n_i,
  input  logic       sw_rst_req_i,
  input  logic       wdt_en_i,
  input  logic       wdt_kick_i,
  output logic       rst_n_o,
  output logic [1:0] rst_cause_o
);

  localparam int              SCW    = $clog2(STRETCH_CYCLES + 1);
  localparam logic [SCW-1:0]  S_LAST = SCW'(STRETCH_CYCLES - 1);

  logic           w_btn_db;
  logic           r_btn_db_d;
  logic           r_sw_s1;
  logic           r_sw_s2;
  logic           r_sw_d;
  logic [1:0]     r_state;
  logic [1:0]     w_state_nxt;
  logic [SCW-1:0] r_cnt;
  logic [SCW-1:0] w_cnt_nxt;
  logic           r_rst_n;
  logic [1:0]     r_cause;
  logic           w_btn_req;
  logic           w_sw_req;
  logic           w_wdt_req;
  logic           w_any_req;

  rst_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_db (
    .i_clk    (sys_clk_pad_i),
    .i_rst_n  (rst_n_pad_i),
    .i_async_n(btn_n_i),
    .o_db     (w_btn_db)
  );

  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      r_sw_s1    <= 1'b0;
      r_sw_s2    <= 1'b0;
      r_sw_d     <= 1'b0;
      r_btn_db_d <= 1'b1;
    end else begin
      r_sw_s1    <= sw_rst_req_i;
      r_sw_s2    <= r_sw_s1;
      r_sw_d     <= r_sw_s2;
      r_btn_db_d <= w_btn_db;
    end
  end

  assign w_btn_req = r_btn_db_d & ~w_btn_db;
  assign w_sw_req  = r_sw_s2 & ~r_sw_d;

`ifdef RST_CTRL_WDT_EN
  localparam int              WCW    = $clog2(WDT_CYCLES + 1);
  localparam logic [WCW-1:0]  W_LAST = WCW'(WDT_CYCLES - 1);

  logic           r_en_s1;
  logic           r_en_s2;
  logic           r_kick_s1;
  logic           r_kick_s2;
  logic           r_kick_d;
  logic [WCW-1:0] r_wdt_cnt;
  logic           w_kick_rise;

  assign w_kick_rise = r_kick_s2 & ~r_kick_d;
  // A kick landing on the terminal count suppresses the expiry.
  assign w_wdt_req   = (r_state == ST_IDLE) & r_en_s2 & ~w_kick_rise & (r_wdt_cnt == W_LAST);

  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      r_en_s1   <= 1'b0;
      r_en_s2   <= 1'b0;
      r_kick_s1 <= 1'b0;
      r_kick_s2 <= 1'b0;
      r_kick_d  <= 1'b0;
      r_wdt_cnt <= '0;
    end else begin
      r_en_s1   <= wdt_en_i;
      r_en_s2   <= r_en_s1;
      r_kick_s1 <= wdt_kick_i;
      r_kick_s2 <= r_kick_s1;
      r_kick_d  <= r_kick_s2;
      if ((r_state != ST_IDLE) || !r_en_s2 || w_kick_rise || w_wdt_req)
        r_wdt_cnt <= '0;
      else
        r_wdt_cnt <= r_wdt_cnt + WCW'(1);
    end
  end
`else
  logic w_unused_wdt;
  assign w_unused_wdt = &{1'b0, wdt_en_i, wdt_kick_i, WDT_CYCLES[0]};
  assign w_wdt_req    = 1'b0;
`endif

  assign w_any_req = w_btn_req | w_sw_req | w_wdt_req;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = '0;
        end
      end
      ST_ASSERT: begin
        if (r_cnt == S_LAST) begin
          w_state_nxt = w_btn_db ? ST_IDLE : ST_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + SCW'(1);
        end
      end
      ST_HOLD: begin
        if (w_btn_db) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_ASSERT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output flop follows the next state so the reset moves on the same edge as the FSM.
  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      r_state <= ST_ASSERT;
      r_cnt   <= '0;
      r_rst_n <= 1'b0;
      r_cause <= CAUSE_POR;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rst_n <= (w_state_nxt == ST_IDLE);
      if ((r_state == ST_IDLE) && w_any_req)
        r_cause <= sel_cause(w_wdt_req, w_sw_req);
    end
  end

  assign rst_n_o     = r_rst_n;
  assign rst_cause_o = r_cause;

endmodule

// File: tb/tb_rst_ctrl.sv
// Directed bench for rst_ctrl with a pulse scoreboard; watchdog scenarios are
// selected by RST_CTRL_WDT_EN.
module tb_rst_ctrl;

  logic       sys_clk_pad_i = 1'b0;
  logic       rst_n_pad_i;
  logic       btn_n_i;
  logic       sw_rst_req_i;
  logic       wdt_en_i;
  logic       wdt_kick_i;
  logic       rst_n_o;
  logic [1:0] rst_cause_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] cause;
    int         len;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  rst_ctrl #(
    .DEBOUNCE_CYCLES(8),
    .STRETCH_CYCLES (16),
    .WDT_CYCLES     (64)
  ) dut (
    .sys_clk_pad_i(sys_clk_pad_i),
    .rst_n_pad_i  (rst_n_pad_i),
    .btn_n_i      (btn_n_i),
    .sw_rst_req_i (sw_rst_req_i),
    .wdt_en_i     (wdt_en_i),
    .wdt_kick_i   (wdt_kick_i),
    .rst_n_o      (rst_n_o),
    .rst_cause_o  (rst_cause_o)
  );

  always #5 sys_clk_pad_i = ~sys_clk_pad_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk_pad_i);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] cause, input int len);
    exp_t x;
    x.cause = cause;
    x.len   = len;
    sb_q.push_back(x);
  endtask

  // Pulse monitor: measures every rst_n_o low pulse that starts outside pad reset.
  initial begin
    logic       m_prev;
    logic       m_in;
    int         m_len;
    logic [1:0] m_cause;
    m_prev = 1'b0;
    m_in   = 1'b0;
    m_len  = 0;
    m_cause = 2'd0;
    forever begin
      @(negedge sys_clk_pad_i);
      if (!rst_n_pad_i) begin
        m_prev = 1'b0;
        m_in   = 1'b0;
      end else begin
        if (m_prev && !rst_n_o) begin
          m_in    = 1'b1;
          m_len   = 1;
          m_cause = rst_cause_o;
        end else if (m_in && !rst_n_o) begin
          m_len++;
        end else if (m_in && rst_n_o) begin
          m_in = 1'b0;
          chk("pulse_expected", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("pulse_len", 32'(m_len), 32'(e.len));
            chk("pulse_cause", 32'(m_cause), 32'(e.cause));
          end
        end
        m_prev = rst_n_o;
      end
    end
  end

  initial begin
    rst_n_pad_i  = 1'b0;
    btn_n_i      = 1'b1;
    sw_rst_req_i = 1'b0;
    wdt_en_i     = 1'b0;
    wdt_kick_i   = 1'b0;

    // Power-on reset and release
    tick(3);
    chk("por_rst_n", 32'(rst_n_o), 32'd0);
    chk("por_cause", 32'(rst_cause_o), 32'd0);
    rst_n_pad_i = 1'b1;
    tick(15);
    chk("por_stretch_low", 32'(rst_n_o), 32'd0);
    tick(1);
    chk("por_release_high", 32'(rst_n_o), 32'd1);
    chk("por_cause_after", 32'(rst_cause_o), 32'd0);
    tick(5);

    // Software request, with a second rise ignored during ASSERT
    push_exp(2'd2, 16);
    sw_rst_req_i = 1'b1;
    tick(2);
    chk("sw_latency_high", 32'(rst_n_o), 32'd1);
    tick(1);
    chk("sw_latency_low", 32'(rst_n_o), 32'd0);
    chk("sw_cause", 32'(rst_cause_o), 32'd2);
    sw_rst_req_i = 1'b0;
    tick(4);
    sw_rst_req_i = 1'b1;
    tick(4);
    sw_rst_req_i = 1'b0;
    tick(12);
    chk("sw_done_high", 32'(rst_n_o), 32'd1);
    chk("sw_cause_kept", 32'(rst_cause_o), 32'd2);
    chk("sw_sb_empty", 32'(sb_q.size()), 32'd0);
    tick(5);

    // Bouncing button: low 3, high 2, low 20, then release (holds in HOLD)
    push_exp(2'd1, 20);
    btn_n_i = 1'b0;
    tick(3);
    btn_n_i = 1'b1;
    tick(2);
    btn_n_i = 1'b0;
    tick(10);
    chk("btn_latency_high", 32'(rst_n_o), 32'd1);
    tick(1);
    chk("btn_latency_low", 32'(rst_n_o), 32'd0);
    chk("btn_cause", 32'(rst_cause_o), 32'd1);
    tick(9);
    btn_n_i = 1'b1;
    tick(15);
    chk("btn_done_high", 32'(rst_n_o), 32'd1);
    chk("btn_sb_empty", 32'(sb_q.size()), 32'd0);
    tick(5);

    // Button and software requests synchronised in the same cycle
    push_exp(2'd2, 16);
    btn_n_i = 1'b0;
    tick(8);
    sw_rst_req_i = 1'b1;
    tick(2);
    chk("both_latency_high", 32'(rst_n_o), 32'd1);
    tick(1);
    chk("both_latency_low", 32'(rst_n_o), 32'd0);
    chk("both_cause", 32'(rst_cause_o), 32'd2);
    btn_n_i = 1'b1;
    sw_rst_req_i = 1'b0;
    tick(20);
    chk("both_done_high", 32'(rst_n_o), 32'd1);
    chk("both_sb_empty", 32'(sb_q.size()), 32'd0);
    tick(5);

`ifdef RST_CTRL_WDT_EN
    // Watchdog expiry without kicks
    push_exp(2'd3, 16);
    wdt_en_i = 1'b1;
    tick(65);
    chk("wdt_before_expiry", 32'(rst_n_o), 32'd1);
    tick(1);
    chk("wdt_expiry_low", 32'(rst_n_o), 32'd0);
    chk("wdt_cause", 32'(rst_cause_o), 32'd3);
    wdt_en_i = 1'b0;
    tick(25);
    chk("wdt_sb_empty", 32'(sb_q.size()), 32'd0);

    // Regular kicks keep the watchdog quiet
    wdt_en_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(49);
      wdt_kick_i = 1'b1;
      tick(1);
      wdt_kick_i = 1'b0;
      chk("wdt_kicked_high", 32'(rst_n_o), 32'd1);
    end
    wdt_en_i = 1'b0;
    tick(5);
    chk("wdt_kick_cause", 32'(rst_cause_o), 32'd3);
`else
    // Watchdog compiled out: enable must never cause a reset
    wdt_en_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(100);
      chk("nowdt_high", 32'(rst_n_o), 32'd1);
      chk("nowdt_cause", 32'(rst_cause_o), 32'd2);
    end
    wdt_en_i = 1'b0;
    tick(5);
`endif

    // Pad reset asserted mid-operation, then a full stretch after release
    rst_n_pad_i = 1'b0;
    #1;
    chk("mid_async_low", 32'(rst_n_o), 32'd0);
    chk("mid_async_cause", 32'(rst_cause_o), 32'd0);
    tick(2);
    rst_n_pad_i = 1'b1;
    tick(15);
    chk("mid_stretch_low", 32'(rst_n_o), 32'd0);
    tick(1);
    chk("mid_release_high", 32'(rst_n_o), 32'd1);
    tick(10);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_ctrl.md
RST_CTRL -- requirements
Module: rst_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles before a button level is accepted.
REQ-002 SHALL have parameter STRETCH_CYCLES, default 1024, minimum rst_n_o low time in cycles.
REQ-003 SHALL have parameter WDT_CYCLES, default 16777216, watchdog timeout in cycles.
REQ-004 SHALL have port sys_clk_pad_i, input, 1: sole clock, board oscillator.
REQ-005 SHALL have port rst_n_pad_i, input, 1: power-on reset; the only clock is sys_clk_pad_i, and this reset is asynchronous, active-low.
REQ-006 SHALL have port btn_n_i, input, 1: async noisy reset pushbutton, active-low.
REQ-007 SHALL have port sw_rst_req_i, input, 1: async software reset request level.
REQ-008 SHALL have port wdt_en_i, input, 1: async watchdog enable level.
REQ-009 SHALL have port wdt_kick_i, input, 1: async watchdog kick level.
REQ-010 SHALL have port rst_n_o, output, 1: registered active-low reset feeding the clock/reset generator reset input.
REQ-011 SHALL have port rst_cause_o, output, 2: cause of last reset (0 POR, 1 button, 2 software, 3 watchdog).

Function
REQ-012 SHALL double-flop synchronise btn_n_i, sw_rst_req_i, wdt_en_i and wdt_kick_i before use.
REQ-013 SHALL update debounced button state btn_db only after the synchronised btn_n_i holds a new level for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-014 SHALL raise requests on: btn_db falling edge (button), synchronised sw_rst_req_i rising edge (software), watchdog expiry (watchdog).
REQ-015 SHALL implement states IDLE, ASSERT, HOLD.
REQ-016 IDLE: rst_n_o=1; any request moves to ASSERT, with rst_n_o=0 on the next cycle (1-cycle latency after the synchronised event).
REQ-017 ASSERT: rst_n_o=0; counter runs 0..STRETCH_CYCLES-1, then HOLD if btn_db is still low, else IDLE.
REQ-018 HOLD: rst_n_o=0 until btn_db goes high, then IDLE.
REQ-019 SHALL ignore requests arriving in ASSERT or HOLD; neither the counter nor rst_cause_o changes.
REQ-020 SHALL load rst_cause_o only on the IDLE->ASSERT transition; on simultaneous requests the priority is watchdog > software > button.
REQ-021 Watchdog counter SHALL increment only in IDLE with synchronised wdt_en_i=1; it clears on a kick rising edge, on wdt_en_i=0, and in ASSERT/HOLD.
REQ-022 Watchdog expiry SHALL occur when the counter reaches WDT_CYCLES-1; a kick in the same cycle wins, giving no expiry.
REQ-023 rst_n_o SHALL be driven directly from a flop, glitch-free.

Reset
REQ-024 On rst_n_pad_i low, asynchronously: state=ASSERT, rst_n_o=0, rst_cause_o=0, all counters 0, btn_db=1, synchronisers=inactive.
REQ-025 Release of rst_n_pad_i mid-operation SHALL run a full STRETCH_CYCLES ASSERT before rst_n_o rises.

Configuration
REQ-026 Macro RST_CTRL_WDT_EN defined: watchdog per REQ-021/022 is compiled in.
REQ-027 Macro RST_CTRL_WDT_EN undefined: no watchdog logic; wdt_en_i and wdt_kick_i remain as unused ports; rst_cause_o never equals 3.

Structure
REQ-028 Package rst_ctrl_pkg SHALL hold the state encoding and the cause codes CAUSE_POR/BTN/SW/WDT.
REQ-029 Sub-module rst_debounce (synchroniser plus debounce counter, parameter DEBOUNCE_CYCLES) SHALL be instantiated for btn_n_i.

Verification (DEBOUNCE_CYCLES=8, STRETCH_CYCLES=16, WDT_CYCLES=64)
REQ-030 Release rst_n_pad_i -> rst_n_o=0 for 16 cycles, then 1; rst_cause_o=0.
REQ-031 btn_n_i bounces low 3 cycles, high 2, then low 20 -> exactly one reset, starting 2+8 cycles after the stable low plus 1; HOLD until release; cause=1.
REQ-032 sw_rst_req_i rises in IDLE -> rst_n_o low 3 cycles later for 16 cycles; cause=2; a second sw rise during ASSERT is ignored.
REQ-033 WDT_EN: wdt_en_i=1 with no kicks -> reset after 64 cycles, cause=3; kicks every 50 cycles -> no reset.
REQ-034 Button and sw events synchronised in the same cycle -> cause=2; without RST_CTRL_WDT_EN, wdt_en_i=1 for 1000 cycles -> no reset.
